lock_access_controller: RTL and testbench
=========================================

Name: lock_access_controller

Overview:
- Downstream stage of the 4-bit code-shift lock. It consumes that lock's `unlock` level together with a per-entry `attempt` strobe from the keypad front end.
- It drives the door actuator for a timed open window.
- It counts consecutive failed attempts and enters a timed lockout with alarm after MAX_FAILS failures.
- All outputs are registered.

Parameters:
MAX_FAILS, 3, consecutive failed attempts that trigger lockout (≥1)
OPEN_CYCLES, 8, clock cycles door_open stays high per granted attempt (≥1)
LOCKOUT_CYCLES, 16, clock cycles lockout/alarm stay high (≥1)
CNT_W, 8, timer width; must satisfy 2^CNT_W > max(OPEN_CYCLES, LOCKOUT_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
attempt  input  1  one-cycle strobe: code entry complete, evaluate unlock this cycle
unlock  input  1  match flag from upstream code lock, sampled only when attempt=1
relock  input  1  level; forces early close of the open window
door_open  output  1  actuator enable
lockout  output  1  high while further attempts are rejected
alarm  output  1  high for the first cycle of every lockout entry (pulse)
fail_count  output  $clog2(MAX_FAILS+1)  current consecutive-failure count

Behaviour:
- Reset (async assert, sync-to-clk deassert is upstream's job):
  - state=IDLE, timer=0, fail_count=0, door_open=0, lockout=0, alarm=0.
  - Reset mid-OPEN or mid-LOCKOUT aborts immediately: outputs drop asynchronously.
- FSM states: IDLE, OPEN, LOCKOUT. door_open=1 iff state==OPEN; lockout=1 iff state==LOCKOUT.
- IDLE, attempt=1, unlock=1:
  - Next state OPEN, timer←OPEN_CYCLES-1, fail_count←0.
  - door_open rises on the edge after the attempt cycle (latency 1) and stays high exactly OPEN_CYCLES cycles.
- IDLE, attempt=1, unlock=0:
  - If fail_count+1 < MAX_FAILS: fail_count increments, stay IDLE.
  - Else: next state LOCKOUT, timer←LOCKOUT_CYCLES-1, fail_count←MAX_FAILS (held during lockout), alarm=1 for that first LOCKOUT cycle only.
- IDLE, attempt=0: hold. unlock is ignored when attempt=0; a steady unlock level never opens the door.
- OPEN:
  - timer decrements each cycle. When timer==0 and no relock: next IDLE.
  - relock=1: next IDLE on that edge regardless of timer.
  - attempt is ignored entirely: no count change, no timer reload.
  - relock and attempt in the same cycle: relock wins, attempt discarded.
- LOCKOUT:
  - timer decrements. When timer==0: next IDLE, fail_count←0.
  - attempt ignored (not counted, not evaluated). relock ignored.
  - lockout is high exactly LOCKOUT_CYCLES cycles.
- relock in IDLE: no effect.
- Timer never wraps: decrement happens only when timer≠0; the terminal transition is taken at 0.
- A successful attempt clears fail_count even if fail_count==MAX_FAILS-1.
- Back-to-back attempts in IDLE on consecutive cycles are each evaluated. The cycle after the entering attempt is already OPEN/LOCKOUT, so it is ignored there.
- All outputs change only on clk edges, except for asynchronous reset.

Test Plan:
- Reset, then attempt=1/unlock=1 at cycle 5 -> door_open=1 cycles 6..13 (8 cycles), 0 at cycle 14; fail_count stays 0; lockout=0.
- Two attempts with unlock=0, then one with unlock=1 -> fail_count 1, 2, then 0; door_open opens for 8 cycles.
- Three consecutive attempts with unlock=0 (cycles 2, 4, 6) -> fail_count=1, 2; cycle 7 lockout=1, alarm=1 for cycle 7 only, fail_count=3; lockout high 16 cycles (7..22); cycle 23 IDLE with fail_count=0.
- During lockout, drive attempt=1/unlock=1 at cycle 10 -> ignored: door_open stays 0 and lockout ends on schedule at cycle 23.
- In OPEN at its 3rd cycle, assert relock and attempt together -> door_open=0 the next cycle, fail_count unchanged, state IDLE.
- Assert reset asynchronously mid-OPEN (between edges) -> door_open drops without waiting for clk; after release, an attempt with unlock=0 gives fail_count=1.

Source files
------------

// File: rtl/lock_access_controller.sv
// Door/lockout controller downstream of the code-shift lock: opens the door for a timed window on
// a matching attempt, counts consecutive failures and enters a timed lockout with an alarm pulse.
module lock_access_controller #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned OPEN_CYCLES    = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           attempt,
  input  logic                           unlock,
  input  logic                           relock,
  output logic                           door_open,
  output logic                           lockout,
  output logic                           alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int unsigned FcW = $clog2(MAX_FAILS + 1);

  localparam logic [FcW-1:0]   MaxFc       = FcW'(MAX_FAILS);
  localparam logic [FcW-1:0]   LastFc      = FcW'(MAX_FAILS - 1);
  localparam logic [CNT_W-1:0] OpenLoad    = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockoutLoad = CNT_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StOpen,
    StLockout
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [FcW-1:0]   fail_q, fail_d;
  logic             alarm_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    alarm_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (attempt) begin
          if (unlock) begin
            state_d = StOpen;
            timer_d = OpenLoad;
            fail_d  = '0;
          end else if (fail_q < LastFc) begin
            fail_d = fail_q + 1'b1;
          end else begin
            state_d = StLockout;
            timer_d = LockoutLoad;
            fail_d  = MaxFc;
            alarm_d = 1'b1;
          end
        end
      end
      StOpen: begin
        // relock overrides the timer; attempts are never evaluated while open
        if (relock || (timer_q == '0)) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
        fail_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      fail_q    <= '0;
      door_open <= 1'b0;
      lockout   <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      fail_q    <= fail_d;
      // Outputs registered from the next-state decode so they track state_q exactly
      door_open <= (state_d == StOpen);
      lockout   <= (state_d == StLockout);
      alarm     <= alarm_d;
    end
  end

  assign fail_count = fail_q;

endmodule

// File: tb/tb_lock_access_controller.sv
// Directed self-checking bench for lock_access_controller with default parameters.
module tb_lock_access_controller;

  logic       clk;
  logic       reset;
  logic       attempt;
  logic       unlock;
  logic       relock;
  logic       door_open;
  logic       lockout;
  logic       alarm;
  logic [1:0] fail_count;

  int n_checks;
  int n_errors;

  lock_access_controller #(
    .MAX_FAILS      (3),
    .OPEN_CYCLES    (8),
    .LOCKOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .attempt    (attempt),
    .unlock     (unlock),
    .relock     (relock),
    .door_open  (door_open),
    .lockout    (lockout),
    .alarm      (alarm),
    .fail_count (fail_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_attempt(input logic unl);
    attempt = 1'b1;
    unlock  = unl;
    step();
    attempt = 1'b0;
    unlock  = 1'b0;
  endtask

  // Called with door_open already sampled high once; returns total high cycles.
  task automatic count_open(output int cnt);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!door_open) break;
      cnt++;
    end
  endtask

  int cnt;
  int door_seen;

  initial begin
    n_checks = 0;
    n_errors = 0;
    attempt  = 1'b0;
    unlock   = 1'b0;
    relock   = 1'b0;
    reset    = 1'b1;
    repeat (2) step();

    check("rst_door", door_open, 0);
    check("rst_lockout", lockout, 0);
    check("rst_alarm", alarm, 0);
    check("rst_fail", fail_count, 0);
    reset = 1'b0;
    step();

    // Steady unlock without attempt never opens
    unlock = 1'b1;
    repeat (3) step();
    check("steady_unlock_door", door_open, 0);
    unlock = 1'b0;

    // Successful attempt: 8-cycle window
    pulse_attempt(1'b1);
    check("open_latency1", door_open, 1);
    check("open_fail0", fail_count, 0);
    count_open(cnt);
    check("open_len", cnt, 8);
    check("open_closed", door_open, 0);
    check("open_no_lockout", lockout, 0);

    // Two failures then success clears the count
    pulse_attempt(1'b0);
    check("fail1", fail_count, 1);
    step();
    pulse_attempt(1'b0);
    check("fail2", fail_count, 2);
    check("fail2_no_lockout", lockout, 0);
    pulse_attempt(1'b1);
    check("succ_clears", fail_count, 0);
    check("succ_door", door_open, 1);
    count_open(cnt);
    check("succ_open_len", cnt, 8);

    // Three failures -> lockout
    pulse_attempt(1'b0);
    step();
    pulse_attempt(1'b0);
    step();
    pulse_attempt(1'b0);
    check("lk_enter", lockout, 1);
    check("lk_alarm", alarm, 1);
    check("lk_fail", fail_count, 3);
    cnt = 1;
    door_seen = 0;
    for (int i = 0; i < 40; i++) begin
      attempt = (i == 2);
      unlock  = (i == 2);
      relock  = (i == 4);
      step();
      if (i == 0) check("lk_alarm_pulse", alarm, 0);
      if (door_open) door_seen = 1;
      if (!lockout) break;
      cnt++;
    end
    attempt = 1'b0;
    unlock  = 1'b0;
    relock  = 1'b0;
    check("lk_len", cnt, 16);
    check("lk_no_door", door_seen, 0);
    check("lk_exit_fail", fail_count, 0);
    check("lk_exit_door", door_open, 0);

    // Relock together with attempt on the 3rd open cycle
    pulse_attempt(1'b1);
    step();
    step();
    check("rl_still_open", door_open, 1);
    relock  = 1'b1;
    attempt = 1'b1;
    unlock  = 1'b0;
    step();
    relock  = 1'b0;
    attempt = 1'b0;
    check("rl_door", door_open, 0);
    check("rl_fail", fail_count, 0);
    step();
    check("rl_idle_door", door_open, 0);
    check("rl_idle_lockout", lockout, 0);

    // Relock in IDLE does nothing; a failure still counts afterwards
    relock = 1'b1;
    step();
    relock = 1'b0;
    check("idle_relock_fail", fail_count, 0);

    // Asynchronous reset mid-open
    pulse_attempt(1'b1);
    step();
    check("ar_open", door_open, 1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_door_async", door_open, 0);
    #1;
    reset = 1'b0;
    step();
    check("ar_after_door", door_open, 0);
    pulse_attempt(1'b0);
    check("ar_fail1", fail_count, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
